// File: rtl/comparator_stimulus.sv
// Stimulus generator and checker for a 1-bit equality comparator: sweeps {x,y} over 00..11,
// checks z against ~(x^y) after a settle delay. Optional error log enabled by CMP_STIM_ERRLOG_EN.
module comparator_stimulus #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt
`ifdef CMP_STIM_ERRLOG_EN
  ,
  output logic [1:0] fail_vec,
  output logic       fail_valid
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LP_LAST_PASS   = 8'(PASSES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_idx;
  logic [7:0] r_pass_cnt;
  logic [3:0] r_settle;
  logic       r_x;
  logic       r_y;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [7:0] r_err;
  logic       w_expected;
  logic       w_last_vec;

  assign w_expected = ~(r_x ^ r_y);
  assign w_last_vec = (r_idx == 2'd3) && !(r_pass_cnt < LP_LAST_PASS);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_DRIVE;
      S_DRIVE:  w_next = S_WAIT;
      S_WAIT:   if (r_settle == 4'd0) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_last_vec ? S_DONE : S_DRIVE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

`ifdef CMP_STIM_ERRLOG_EN
  logic [1:0] r_fail_vec;
  logic       r_fail_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fail_vec   <= 2'b00;
      r_fail_valid <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_fail_vec   <= 2'b00;
      r_fail_valid <= 1'b0;
    end else if (r_state == S_SAMPLE && z != w_expected && !r_fail_valid) begin
      r_fail_vec   <= {r_x, r_y};
      r_fail_valid <= 1'b1;
    end
  end

  assign fail_vec   = r_fail_vec;
  assign fail_valid = r_fail_valid;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx      <= 2'd0;
      r_pass_cnt <= 8'd0;
      r_settle   <= 4'd0;
      r_x        <= 1'b0;
      r_y        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_x <= 1'b0;
          r_y <= 1'b0;
          if (start) begin
            r_busy     <= 1'b1;
            r_err      <= 8'd0;
            r_pass     <= 1'b0;
            r_idx      <= 2'd0;
            r_pass_cnt <= 8'd0;
          end
        end
        S_DRIVE: begin
          r_x      <= r_idx[1];
          r_y      <= r_idx[0];
          r_settle <= LP_SETTLE_LOAD;
        end
        S_WAIT: begin
          if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
        end
        S_SAMPLE: begin
          // Count saturates at 255 so long runs never wrap back to a passing value.
          if (z != w_expected && r_err != 8'hFF) r_err <= r_err + 8'd1;
          if (r_idx != 2'd3) begin
            r_idx <= r_idx + 2'd1;
          end else if (r_pass_cnt < LP_LAST_PASS) begin
            r_idx      <= 2'd0;
            r_pass_cnt <= r_pass_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_pass <= (r_err == 8'd0);
          r_x    <= 1'b0;
          r_y    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign x       = r_x;
  assign y       = r_y;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err;

endmodule

// File: tb/tb_comparator_stimulus.sv
// Self-checking bench for comparator_stimulus: the comparator under test is modelled as a
// 4-entry truth table indexed by {x,y}; expectations come from counting table mismatches.
module tb_comparator_stimulus;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       x, y, z;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [3:0] r_tbl;

  logic       s_start;
  logic       s_x, s_y, s_z;
  logic       s_busy, s_done, s_pass;
  logic [7:0] s_err_cnt;

`ifdef CMP_STIM_ERRLOG_EN
  logic [1:0] fail_vec, s_fail_vec;
  logic       fail_valid, s_fail_valid;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign z   = r_tbl[{x, y}];
  assign s_z = 1'b0;

  comparator_stimulus dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .z(z),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef CMP_STIM_ERRLOG_EN
    , .fail_vec(fail_vec), .fail_valid(fail_valid)
`endif
  );

  comparator_stimulus #(.SETTLE_CYCLES(1), .PASSES(255)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .x(s_x), .y(s_y), .z(s_z),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err_cnt)
`ifdef CMP_STIM_ERRLOG_EN
    , .fail_vec(s_fail_vec), .fail_valid(s_fail_valid)
`endif
  );

  typedef struct {
    string      name;
    logic [3:0] tbl;
    logic [7:0] exp_err;
    logic [1:0] exp_fvec;
    logic       exp_fvalid;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a correct comparator outputs 1 exactly when x == y.
  function automatic void model(input logic [3:0] tbl, input int passes,
                                output logic [7:0] err, output logic [1:0] fvec,
                                output logic fvalid);
    int mism = 0;
    fvalid = 1'b0;
    fvec   = 2'b00;
    for (int i = 0; i < 4; i++) begin
      logic good = (((i >> 1) & 1) == (i & 1));
      if (tbl[i] != good) begin
        mism++;
        if (!fvalid) begin
          fvalid = 1'b1;
          fvec   = 2'(i);
        end
      end
    end
    mism = mism * passes;
    err  = (mism > 255) ? 8'd255 : 8'(mism);
  endfunction

  task automatic do_run(input vec_t v);
    int n = 0;
    int seq_bad = 0;
    r_tbl = v.tbl;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({v.name, "_busy_start"}, busy, 1);
    while (!done && n < 200) begin
      @(posedge clk);
      #1 n++;
      if (!done && int'({x, y}) != ((n - 1) / 4) % 4) seq_bad++;
    end
    check({v.name, "_done_cycle"}, n, 17);
    check({v.name, "_xy_seq_errors"}, seq_bad, 0);
    check({v.name, "_err_cnt"}, err_cnt, v.exp_err);
    check({v.name, "_pass"}, pass, (v.exp_err == 0) ? 1 : 0);
    check({v.name, "_busy_end"}, busy, 0);
`ifdef CMP_STIM_ERRLOG_EN
    check({v.name, "_fail_valid"}, fail_valid, v.exp_fvalid);
    if (v.exp_fvalid) check({v.name, "_fail_vec"}, fail_vec, v.exp_fvec);
`endif
    @(posedge clk);
    #1 check({v.name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    vec_t vecs[11];
    int   n, first_done, second_done, dones;

    vecs[0] = '{"ideal",  4'b1001, 8'd0, 2'b00, 1'b0};
    vecs[1] = '{"stuck0", 4'b0000, 8'd2, 2'b00, 1'b1};
    vecs[2] = '{"stuck1", 4'b1111, 8'd2, 2'b01, 1'b1};
    vecs[3] = '{"invert", 4'b0110, 8'd4, 2'b00, 1'b1};
    for (int k = 4; k < 11; k++) begin
      vecs[k].name = $sformatf("rand%0d", k);
      vecs[k].tbl  = 4'($urandom);
      model(vecs[k].tbl, 1, vecs[k].exp_err, vecs[k].exp_fvec, vecs[k].exp_fvalid);
    end

    rst_n   = 1'b0;
    start   = 1'b0;
    s_start = 1'b0;
    r_tbl   = 4'b1001;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_xy", {x, y}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) do_run(vecs[k]);

    // Mid-run start pulse is ignored: run length unchanged.
    r_tbl = 4'b1001;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1 n++;
      start = (n == 6);
    end
    start = 1'b0;
    check("ignore_start_len", n, 17);
    @(posedge clk);
    #1 check("ignore_start_idle", busy, 0);

    // Reset during WAIT of vector 10 aborts the run with no done.
    r_tbl = 4'b0000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("abort_pre_xy", {x, y}, 2);
    check("abort_pre_err", err_cnt, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check("abort_busy", busy, 0);
    check("abort_xy", {x, y}, 0);
    check("abort_err", err_cnt, 0);
    check("abort_done", done, 0);
    rst_n = 1'b1;
    dones = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    check("abort_no_done", dones, 0);

    do_run(vecs[0]);

    // Start held high: second run begins the cycle after DONE.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 n = 0;
    first_done = 0;
    second_done = 0;
    while (second_done == 0 && n < 200) begin
      @(posedge clk);
      #1 n++;
      if (done && first_done == 0) begin
        first_done = n;
        check("held_busy_at_done", busy, 0);
      end else if (done) begin
        second_done = n;
      end
    end
    start = 1'b0;
    check("held_first_done", first_done, 17);
    check("held_second_done", second_done, 35);
    repeat (3) @(posedge clk);

    // Saturation: PASSES=255, SETTLE=1, z stuck 0 -> 510 mismatches.
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    n = 0;
    while (!s_done && n < 4000) begin
      @(posedge clk);
      #1 n++;
    end
    check("sat_done_cycle", n, 255 * 4 * 3 + 1);
    check("sat_err", s_err_cnt, 255);
    check("sat_pass", s_pass, 0);
`ifdef CMP_STIM_ERRLOG_EN
    check("sat_fail_vec", s_fail_vec, 0);
    check("sat_fail_valid", s_fail_valid, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
